// File: rtl/uart_pkg.sv
// Shared UART receive definitions.
// Holds the FSM state type, frame defaults and the mid-bit sample point.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;
  localparam int MID_SAMPLE     = OVERSAMPLE_DEF / 2 - 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Tick index at which the start bit is re-checked mid-period.
  function automatic int mid_sample(input int os);
    return os / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset high so an idle line never looks like a start bit.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: oversampled start/data/stop framing with a
// one-entry output holding register, frame error and overrun pulses.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_16x,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] MID =
    CW'(mid_sample(OVERSAMPLE));
  localparam logic [CW-1:0] LAST =
    CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT =
    BW'(DATA_BITS - 1);

  logic rxd_s;

  rx_state_t            state, state_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [BW-1:0]        bit_idx, bit_nx;
  logic [DATA_BITS-1:0] sr, sr_nx;
  logic                 deliver;
  logic                 ferr_set;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sr      <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_nx;
      sr      <= sr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bit_nx   = bit_idx;
    sr_nx    = sr;
    deliver  = 1'b0;
    ferr_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick_16x && !rxd_s) begin
          state_nx = START;
          cnt_nx   = '0;
        end
      end
      START: begin
        if (tick_16x) begin
          if (cnt == MID) begin
            cnt_nx   = '0;
            bit_nx   = '0;
            state_nx = rxd_s ? IDLE : DATA;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick_16x) begin
          if (cnt == LAST) begin
            // LSB arrives first, so shift in from the top
            sr_nx  = DATA_BITS'({rxd_s, sr} >> 1);
            cnt_nx = '0;
            bit_nx = bit_idx + 1'b1;
            if (bit_idx == LAST_BIT)
              state_nx = STOP;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick_16x) begin
          if (cnt == LAST) begin
            cnt_nx = '0;
            if (rxd_s) begin
              deliver  = 1'b1;
              state_nx = IDLE;
            end else begin
              ferr_set = 1'b1;
              state_nx = WAIT_HIGH;
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        if (rxd_s)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Holding register: a handshake in the delivery cycle frees the slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overrun   <= 1'b0;
      if (deliver) begin
        if (!data_valid || data_ready) begin
          data_out   <= sr;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
